store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 15 +
 rtl/sb_fifo.sv | 64 ++++++
 rtl/store_buffer.sv | 74 +++++++
 tb/tb_store_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared constants and the buffered-store entry type for the store buffer.
package sb_pkg;

  localparam int DefaultDepth  = 4;
  localparam int WordAddrWidth = 12;
  localparam int DataWidth     = 32;
  localparam int StrobeWidth   = 4;

  typedef struct packed {
    logic [WordAddrWidth-1:0] addr;
    logic [StrobeWidth-1:0]   strb;
    logic [DataWidth-1:0]     data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Entry storage for the store buffer: circular FIFO with per-slot valid bits
// and a parallel word-address compare across all valid slots.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  sb_entry_t                push_entry,
  input  logic [WordAddrWidth-1:0] match_addr,
  output sb_entry_t                head_entry,
  output logic                     match,
  output logic                     full,
  output logic                     empty
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PtrW-1:0]  head;
  logic [PtrW-1:0]  tail;
  logic [CntW-1:0]  count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        entries[tail] <= push_entry;
        valid[tail]   <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr == match_addr)) match = 1'b1;
    end
  end

  assign head_entry = entries[head];
  assign full       = (count == CntW'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// CPU-side store buffer in front of a single-port SRAM: loads win the port,
// buffered stores drain in order whenever the port is otherwise idle.
module store_buffer #(
  parameter int DEPTH         = sb_pkg::DefaultDepth,
  parameter int WordAddrWidth = sb_pkg::WordAddrWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_read,
  input  logic [3:0]               data_write,
  input  logic [31:0]              data_addr,
  input  logic [31:0]              data_in,
  output logic [31:0]              data_out,
  output logic                     cpu_stall,
  output logic [WordAddrWidth-1:0] sram_addr,
  output logic                     sram_read,
  output logic [3:0]               sram_write,
  output logic [31:0]              sram_di,
  input  logic [31:0]              sram_do,
  output logic                     sb_empty
);
  import sb_pkg::*;

  sb_entry_t   push_entry;
  sb_entry_t   head_entry;
  logic        match, full, empty;
  logic        store_req, load_hit, load_go, push, drain;
  logic [11:0] word_addr;
  logic        unused_addr_bits;

  assign word_addr        = data_addr[13:2];
  assign unused_addr_bits = ^{data_addr[31:14], data_addr[1:0]};

  assign store_req  = |data_write;
  // Reset masks stale matches so a load during reset goes straight to SRAM.
  assign load_hit   = data_read && match && !rst;
  assign load_go    = data_read && !load_hit;
  assign push       = store_req && !full;
  assign drain      = !empty && !load_go && !rst;
  assign cpu_stall  = !rst && (load_hit || (store_req && full));
  assign sb_empty   = empty;
  assign push_entry = '{addr: word_addr, strb: data_write, data: data_in};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (drain),
    .push_entry (push_entry),
    .match_addr (word_addr),
    .head_entry (head_entry),
    .match      (match),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    sram_read  = 1'b0;
    sram_write = '0;
    sram_addr  = '0;
    sram_di    = '0;
    data_out   = '0;
    if (load_go) begin
      sram_read = 1'b1;
      sram_addr = WordAddrWidth'(word_addr);
      data_out  = sram_do;
    end else if (drain) begin
      sram_write = head_entry.strb;
      sram_addr  = WordAddrWidth'(head_entry.addr);
      sram_di    = head_entry.data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model of the buffer and SRAM,
// checked every cycle, plus directed scenario checks.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_read;
  logic [3:0]  data_write;
  logic [31:0] data_addr, data_in, data_out;
  logic        cpu_stall;
  logic [11:0] sram_addr;
  logic        sram_read;
  logic [3:0]  sram_write;
  logic [31:0] sram_di, sram_do;
  logic        sb_empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .WordAddrWidth(12)) dut (
    .clk(clk), .rst(rst), .data_read(data_read), .data_write(data_write),
    .data_addr(data_addr), .data_in(data_in), .data_out(data_out),
    .cpu_stall(cpu_stall), .sram_addr(sram_addr), .sram_read(sram_read),
    .sram_write(sram_write), .sram_di(sram_di), .sram_do(sram_do),
    .sb_empty(sb_empty)
  );

  logic [31:0] sram_mem [4096];
  logic [31:0] ref_mem  [4096];
  assign sram_do = sram_mem[sram_addr];

  typedef struct {
    logic [11:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] wr_log[$];
  logic [11:0] wr_alog[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        overlap_ok = 1'b0;

  logic        obs_stall, obs_rd;
  logic [3:0]  obs_wr;
  logic [11:0] obs_addr;
  logic [31:0] obs_di, obs_out;

  // Simultaneous load+store is only driven deliberately, to fill the buffer.
  always @(posedge clk)
    if (rst !== 1'b1 && !overlap_ok)
      assert (!(data_read && (|data_write))) else $error("illegal load+store overlap");

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] s,
                                        input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  task automatic cycle(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] din, input logic r);
    logic        hit, e_stall, e_rd, e_drain, e_empty, was_full;
    logic [11:0] wa, e_addr;
    logic [3:0]  e_wr;
    logic [31:0] e_di, e_out;
    rst = r; data_read = rd; data_write = wr; data_addr = addr; data_in = din;
    #1;
    wa  = addr[13:2];
    hit = 1'b0;
    foreach (q[i]) if (q[i].a == wa) hit = 1'b1;
    if (r) hit = 1'b0;
    was_full = (q.size() == DEPTH);
    e_rd     = rd && !hit;
    e_stall  = !r && ((rd && hit) || ((wr != 0) && was_full));
    e_drain  = !r && (q.size() > 0) && !e_rd;
    e_empty  = (q.size() == 0);
    e_addr = '0; e_wr = '0; e_di = '0; e_out = '0;
    if (e_rd) begin
      e_addr = wa; e_out = ref_mem[wa];
    end else if (e_drain) begin
      e_addr = q[0].a; e_wr = q[0].s; e_di = q[0].d;
    end
    obs_stall = cpu_stall; obs_rd = sram_read; obs_wr = sram_write;
    obs_addr = sram_addr; obs_di = sram_di; obs_out = data_out;
    n_checks++;
    if (cpu_stall !== e_stall) $display("FAIL cyc_stall t=%0t got %b want %b", $time, cpu_stall, e_stall);
    else n_pass++;
    n_checks++;
    if (sram_read !== e_rd) $display("FAIL cyc_sram_read t=%0t got %b want %b", $time, sram_read, e_rd);
    else n_pass++;
    n_checks++;
    if (sram_write !== e_wr) $display("FAIL cyc_sram_write t=%0t got %h want %h", $time, sram_write, e_wr);
    else n_pass++;
    n_checks++;
    if (sram_addr !== e_addr) $display("FAIL cyc_sram_addr t=%0t got %h want %h", $time, sram_addr, e_addr);
    else n_pass++;
    n_checks++;
    if (sram_di !== e_di) $display("FAIL cyc_sram_di t=%0t got %h want %h", $time, sram_di, e_di);
    else n_pass++;
    n_checks++;
    if (data_out !== e_out) $display("FAIL cyc_data_out t=%0t got %h want %h", $time, data_out, e_out);
    else n_pass++;
    n_checks++;
    if (sb_empty !== e_empty) $display("FAIL cyc_sb_empty t=%0t got %b want %b", $time, sb_empty, e_empty);
    else n_pass++;
    if (sram_write != 0) begin
      sram_mem[sram_addr] = merge(sram_mem[sram_addr], sram_write, sram_di);
      wr_log.push_back(sram_di);
      wr_alog.push_back(sram_addr);
    end
    if (r) q.delete();
    else begin
      if (e_drain) begin
        ref_mem[q[0].a] = merge(ref_mem[q[0].a], q[0].s, q[0].d);
        void'(q.pop_front());
      end
      if ((wr != 0) && !was_full) q.push_back('{wa, wr, din});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain_all(input int budget);
    for (int k = 0; k < budget && q.size() > 0; k++) idle();
    n_checks++;
    if (q.size() != 0 || sb_empty !== 1'b1)
      $display("FAIL drain_all got entries=%0d sb_empty=%b want 0/1", q.size(), sb_empty);
    else n_pass++;
  endtask

  task automatic test_reset();
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    cycle(1'b1, 4'h0, 32'h40, 32'h0, 1'b1);
    n_checks++;
    if (obs_rd !== 1'b1 || obs_addr !== 12'h010)
      $display("FAIL reset_load got rd=%b addr=%h want 1/010", obs_rd, obs_addr);
    else n_pass++;
    idle();
    n_checks++;
    if (sb_empty !== 1'b1 || obs_stall !== 1'b0)
      $display("FAIL reset_state got empty=%b stall=%b want 1/0", sb_empty, obs_stall);
    else n_pass++;
  endtask

  task automatic test_single_store();
    cycle(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    idle();
    n_checks++;
    if (obs_wr !== 4'hF || obs_addr !== 12'h004 || obs_di !== 32'hDEADBEEF)
      $display("FAIL single_store got wr=%h addr=%h di=%h want f/004/deadbeef", obs_wr, obs_addr, obs_di);
    else n_pass++;
    n_checks++;
    if (sb_empty !== 1'b1) $display("FAIL single_store_empty got %b want 1", sb_empty);
    else n_pass++;
  endtask

  task automatic test_load_hit();
    int stalls = 0;
    cycle(1'b0, 4'b0011, 32'h20, 32'h0000ABCD, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
      if (obs_stall) stalls++;
      else break;
    end
    n_checks++;
    if (stalls != 1) $display("FAIL load_hit_stalls got %0d want 1", stalls);
    else n_pass++;
    n_checks++;
    if (obs_rd !== 1'b1 || obs_out[15:0] !== 16'hABCD)
      $display("FAIL load_hit_data got rd=%b out=%h want 1/????abcd", obs_rd, obs_out);
    else n_pass++;
  endtask

  task automatic test_load_miss();
    cycle(1'b0, 4'hF, 32'h80, 32'h12345678, 1'b0);
    cycle(1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
    n_checks++;
    if (obs_stall !== 1'b0 || obs_rd !== 1'b1 || obs_addr !== 12'h010 || obs_wr !== 4'h0)
      $display("FAIL load_miss got stall=%b rd=%b addr=%h wr=%h want 0/1/010/0",
               obs_stall, obs_rd, obs_addr, obs_wr);
    else n_pass++;
    idle();
    n_checks++;
    if (obs_wr !== 4'hF || obs_addr !== 12'h020)
      $display("FAIL load_miss_drain got wr=%h addr=%h want f/020", obs_wr, obs_addr);
    else n_pass++;
  endtask

  task automatic test_full_stall();
    wr_log.delete();
    overlap_ok = 1'b1;
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'hF, 32'h100 + 32'(i * 4), 32'(i), 1'b0);
    n_checks++;
    if (obs_stall !== 1'b1) $display("FAIL full_stall_fifth got %b want 1", obs_stall);
    else n_pass++;
    overlap_ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'hF, 32'h114, 32'd5, 1'b0);
      if (!obs_stall) break;
    end
    drain_all(20);
    n_checks++;
    if (wr_log.size() != 5) $display("FAIL full_stall_count got %0d want 5", wr_log.size());
    else n_pass++;
    for (int i = 0; i < wr_log.size() && i < 5; i++) begin
      n_checks++;
      if (wr_log[i] !== 32'(i + 1)) $display("FAIL full_stall_order[%0d] got %h want %h", i, wr_log[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_flush();
    int n0;
    overlap_ok = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'hF, 32'h200 + 32'(i * 4), $urandom, 1'b0);
    cycle(1'b0, 4'hF, 32'h300, 32'hAAAA, 1'b1);
    overlap_ok = 1'b0;
    n_checks++;
    if (sb_empty !== 1'b1) $display("FAIL reset_flush_empty got %b want 1", sb_empty);
    else n_pass++;
    n0 = wr_log.size();
    repeat (5) idle();
    n_checks++;
    if (wr_log.size() != n0) $display("FAIL reset_flush_writes got %0d want %0d", wr_log.size(), n0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d[$];
    logic [11:0] exp_a[$];
    logic [31:0] d, a;
    wr_log.delete();
    wr_alog.delete();
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      a = 32'h1000 + 32'(i * 4);
      exp_d.push_back(d);
      exp_a.push_back(a[13:2]);
      cycle(1'b0, 4'hF, a, d, 1'b0);
      repeat ($urandom_range(0, 2)) idle();
    end
    drain_all(20);
    n_checks++;
    if (wr_log.size() != 10) $display("FAIL wrap_count got %0d want 10", wr_log.size());
    else n_pass++;
    for (int i = 0; i < wr_log.size() && i < 10; i++) begin
      n_checks++;
      if (wr_log[i] !== exp_d[i] || wr_alog[i] !== exp_a[i])
        $display("FAIL wrap_order[%0d] got %h@%h want %h@%h", i, wr_log[i], wr_alog[i], exp_d[i], exp_a[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic        rd, r;
    logic [3:0]  wr;
    logic [31:0] a, d;
    rd = 0; wr = 0; a = 0; d = 0;
    for (int k = 0; k < 400; k++) begin
      if (!obs_stall) begin
        rd = 0; wr = 0; d = $urandom;
        a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 7)) << 2);
        case ($urandom_range(0, 2))
          1: rd = 1'b1;
          2: wr = 4'($urandom_range(1, 15));
          default: ;
        endcase
      end
      r = ($urandom_range(0, 49) == 0);
      cycle(rd, wr, a, d, r);
      if (r) obs_stall = 1'b0;
    end
    drain_all(20);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got no finish want finish by 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    rst = 1'b1; data_read = 1'b0; data_write = 4'h0; data_addr = '0; data_in = '0;
    obs_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single_store();
    test_load_hit();
    test_load_miss();
    test_full_stall();
    test_reset_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
